// File: rtl/hex_pwm.sv
// rtl/hex_pwm.sv - 16-slot PWM driven by an external hex counter, with buffered duty and sequence checking
module hex_pwm (
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] cnt,
  input  logic [3:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  input  logic       en,
  input  logic       err_clr,
  output logic       pwm,
  output logic       period_end,
  output logic       seq_err,
  output logic [3:0] duty_cur
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt_d;
  logic [3:0] cnt_inc;
  logic [3:0] pend;
  logic [3:0] pend_nxt;
  logic [3:0] duty_nxt;
  logic       primed;
  logic       wrap;
  logic       seq_set;

  // A wrap is only trusted once cnt_d holds a real sample, and only for the 15 -> 0 step.
  assign wrap    = primed & (cnt_d == 4'hF) & (cnt == 4'h0);
  assign cnt_inc = cnt_d + 4'd1;
  assign seq_set = primed & (cnt != cnt_inc);

  // Duty buffer state register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Duty buffer next state: accept into pend when empty, promote pend to duty_cur on a wrap.
  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend;
    duty_nxt   = duty_cur;
    duty_ready = 1'b0;
    case (state)
      EMPTY: begin
        duty_ready = 1'b1;
        if (duty_valid) begin
          pend_nxt  = duty_in;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (wrap) begin
          duty_nxt  = pend;
          state_nxt = EMPTY;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Datapath registers; pwm compares against the duty that applies from this edge on,
  // so a new duty is visible starting with slot 0 of the new period.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_d      <= 4'h0;
      primed     <= 1'b0;
      pend       <= 4'h0;
      duty_cur   <= 4'h0;
      pwm        <= 1'b0;
      period_end <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      cnt_d      <= cnt;
      primed     <= 1'b1;
      pend       <= pend_nxt;
      duty_cur   <= duty_nxt;
      pwm        <= en & (cnt < duty_nxt);
      period_end <= wrap;
      seq_err    <= seq_set | (seq_err & ~err_clr);
    end
  end

endmodule

// File: doc/hex_pwm.md
HEX_PWM -- requirements
Module: hex_pwm

Interface
REQ-001 The module SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock shared with the upstream 4-bit hex counter.
REQ-003 Port: res  input  1  asynchronous active-high reset; asserts immediately, releases synchronously to clk.
REQ-004 Port: cnt  input  4  count from the upstream hex counter; nominally +1 mod 16 per clk.
REQ-005 Port: duty_in  input  4  requested duty, i.e. high slots per 16-slot period.
REQ-006 Port: duty_valid  input  1  duty_in is offered.
REQ-007 Port: duty_ready  output  1  the pending duty buffer can accept a value.
REQ-008 Port: en  input  1  output enable.
REQ-009 Port: err_clr  input  1  synchronous clear for seq_err.
REQ-010 Port: pwm  output  1  registered PWM output.
REQ-011 Port: period_end  output  1  one-cycle pulse per detected wrap.
REQ-012 Port: seq_err  output  1  sticky count-sequence error flag.
REQ-013 Port: duty_cur  output  4  duty currently applied.

Function
REQ-014 The block SHALL register cnt into cnt_d every cycle.
REQ-015 The block SHALL set a primed flag on the first clock edge after reset and hold it until the next reset.
REQ-016 wrap SHALL be defined as primed AND cnt_d==15 AND cnt==0.
REQ-017 Duty buffering SHALL be a two-state machine:
  - EMPTY: duty_ready=1; duty_valid=1 captures duty_in into pend and moves to FULL.
  - FULL: duty_ready=0; on a wrap cycle, duty_cur<=pend and the machine moves to EMPTY.
REQ-018 duty_ready SHALL equal (state==EMPTY), combinationally.
REQ-019 A value accepted in EMPTY on a wrap cycle SHALL be captured into pend and applied at the following wrap, not the current one.
REQ-020 duty_cur SHALL change only on wrap cycles.
REQ-021 While FULL, duty_in and duty_valid SHALL be ignored, with no overwrite of pend.
REQ-022 Let duty_nxt be the value duty_cur takes at this edge.
REQ-023 At each edge, pwm SHALL be loaded with en AND (cnt < duty_nxt), an unsigned 4-bit compare.
REQ-024 pwm SHALL therefore lag cnt by one cycle, and a new duty SHALL take effect starting at slot 0 of the new period.
REQ-025 Duty 0 SHALL give pwm constantly 0; duty 15 SHALL give 15 high cycles per 16; duty 16/16 is not representable.
REQ-026 en=0 SHALL force pwm to 0 at the next edge; the handshake, wrap detection and seq_err SHALL continue unaffected.
REQ-027 period_end SHALL be registered and high for exactly the cycle after each wrap cycle.
REQ-028 seq_err SHALL set when primed AND cnt != (cnt_d+1) mod 16.
REQ-029 seq_err SHALL hold until err_clr=1 or reset; if set and clear coincide, set SHALL win.
REQ-030 A non-sequential jump into 0 that is not from 15 SHALL NOT count as a wrap; it SHALL set seq_err.

Reset
REQ-031 Reset SHALL force: pwm=0, period_end=0, seq_err=0, duty_cur=0, pend=0, state=EMPTY (duty_ready=1), primed=0, cnt_d=0.
REQ-032 Reset asserted mid-period SHALL discard any pending duty.
REQ-033 After reset release, the first edge SHALL produce no wrap and no seq_err, regardless of cnt.

Verification
REQ-034 The bench SHALL cover at least these directed scenarios:
  - Reset, free-running cnt 0..15, duty_in=4 offered at cnt=7 -> duty_ready drops; duty_cur becomes 4 at the wrap; pwm high for exactly 4 cycles per period starting one cycle after cnt=0; period_end pulses every 16 cycles.
  - duty_valid held with duty_in=9 then 2 while FULL -> only 9 is accepted, 2 is ignored until duty_ready returns to 1.
  - Accept duty_in=6 exactly on the wrap cycle (cnt_d=15, cnt=0) -> duty_cur is unchanged this period and becomes 6 at the next wrap.
  - cnt jumps 5->9 -> seq_err=1 the next cycle and stays set; err_clr=1 for one cycle -> 0; a jump 3->0 sets seq_err with no period_end.
  - duty 15 with en toggled low for 3 cycles -> pwm=0 during those cycles (one cycle late); duty 0 -> pwm never high.
  - res asserted mid-period with FULL pending -> all outputs reach reset values asynchronously; after release no period_end or seq_err on the first edge.
